// File: rtl/timerio.sv
// Programmable 16-bit interval timer peripheral for the p601zero CPU bus.
// Prescaled down-counter with auto-reload, oneshot mode, expiry flag and level irq.
module timerio #(
  parameter logic [15:0] RESET_RELOAD   = 16'hFFFF,
  parameter logic [7:0]  RESET_PRESCALE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       irq,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs
);

  logic        enable_q, enable_d;
  logic        irq_en_q, irq_en_d;
  logic        oneshot_q, oneshot_d;
  logic        expired_q, expired_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [7:0]  hi_buf_q, hi_buf_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [7:0]  lo_shadow_q, lo_shadow_d;

  logic wr_stb, rd_stb, tick, zero_tick;

  assign wr_stb    = cs & ~rw;
  assign rd_stb    = cs & rw;
  assign tick      = enable_q && (pcnt_q == prescale_q);
  assign zero_tick = tick && (count_q == 16'h0000);

  always_comb begin
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    oneshot_d   = oneshot_q;
    expired_d   = expired_q;
    prescale_d  = prescale_q;
    hi_buf_d    = hi_buf_q;
    reload_d    = reload_q;
    count_d     = count_q;
    pcnt_d      = pcnt_q;
    lo_shadow_d = lo_shadow_q;

    if (enable_q) begin
      pcnt_d = tick ? 8'h00 : pcnt_q + 8'h01;
    end
    if (tick) begin
      if (zero_tick) begin
        expired_d = 1'b1;
        count_d   = reload_q;
        if (oneshot_q) enable_d = 1'b0;
      end else begin
        count_d = count_q - 16'h0001;
      end
    end

    // Bus writes are applied last so they override same-edge timer activity.
    if (wr_stb) begin
      case (AD)
        3'd0: begin
          enable_d  = DI[0];
          irq_en_d  = DI[1];
          oneshot_d = DI[2];
          if (DI[0] && !enable_q) begin
            count_d = reload_q;
            pcnt_d  = 8'h00;
          end
          if (!DI[0]) pcnt_d = 8'h00;
        end
        3'd1: begin
          // A same-edge expiry beats the write-1-clear.
          if (DI[0] && !zero_tick) expired_d = 1'b0;
        end
        3'd2: prescale_d = DI;
        3'd3: hi_buf_d = DI;
        3'd4: begin
          reload_d = {hi_buf_q, DI};
          count_d  = {hi_buf_q, DI};
          pcnt_d   = 8'h00;
        end
        default: ;
      endcase
    end

    // Latching the low byte with the high-byte read gives a coherent pair.
    if (rd_stb && (AD == 3'd5)) lo_shadow_d = count_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      oneshot_q   <= 1'b0;
      expired_q   <= 1'b0;
      prescale_q  <= RESET_PRESCALE;
      hi_buf_q    <= RESET_RELOAD[15:8];
      reload_q    <= RESET_RELOAD;
      count_q     <= RESET_RELOAD;
      pcnt_q      <= 8'h00;
      lo_shadow_q <= 8'h00;
    end else begin
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      oneshot_q   <= oneshot_d;
      expired_q   <= expired_d;
      prescale_q  <= prescale_d;
      hi_buf_q    <= hi_buf_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      pcnt_q      <= pcnt_d;
      lo_shadow_q <= lo_shadow_d;
    end
  end

  always_comb begin
    DO = 8'h00;
    case (AD)
      3'd0: DO = {5'b00000, oneshot_q, irq_en_q, enable_q};
      3'd1: DO = {6'b000000, enable_q, expired_q};
      3'd2: DO = prescale_q;
      3'd3: DO = hi_buf_q;
      3'd4: DO = reload_q[7:0];
      3'd5: DO = count_q[15:8];
      3'd6: DO = lo_shadow_q;
      default: DO = 8'h00;
    endcase
  end

  assign irq = expired_q & irq_en_q;

endmodule

// File: tb/tb_timerio.sv
// Bench for timerio: directed literal checks plus randomized bus traffic
// compared every cycle against a behavioural timer model.
module tb_timerio;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       irq;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       rw = 1'b1;
  logic       cs = 1'b0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  timerio dut (
    .clk(clk), .rst(rst), .irq(irq), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit          m_en, m_ien, m_os, m_exp;
  logic [7:0]  m_pre, m_hi, m_pcnt, m_shadow;
  logic [15:0] m_reload, m_count;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mdo(input logic [2:0] a);
    case (a)
      3'd0: return {5'd0, m_os, m_ien, m_en};
      3'd1: return {6'd0, m_en, m_exp};
      3'd2: return m_pre;
      3'd3: return m_hi;
      3'd4: return m_reload[7:0];
      3'd5: return m_count[15:8];
      3'd6: return m_shadow;
      default: return 8'h00;
    endcase
  endfunction

  // One clock of the timer: time advance first, then the bus access, which dominates.
  always @(posedge clk) begin
    if (rst) begin
      m_en = 0; m_ien = 0; m_os = 0; m_exp = 0;
      m_pre = 8'h00; m_hi = 8'hFF; m_reload = 16'hFFFF; m_count = 16'hFFFF;
      m_pcnt = 8'h00; m_shadow = 8'h00;
    end else begin
      bit          was_en, expiry;
      logic [15:0] old_count;
      was_en = m_en;
      old_count = m_count;
      expiry = 0;
      if (m_en && m_pcnt == m_pre) begin
        m_pcnt = 8'h00;
        if (m_count == 0) begin
          expiry = 1;
          m_exp = 1;
          m_count = m_reload;
          if (m_os) m_en = 0;
        end else m_count = m_count - 16'd1;
      end else if (m_en) m_pcnt = m_pcnt + 8'd1;
      if (cs && !rw) begin
        case (AD)
          3'd0: begin
            if (DI[0] && !was_en) begin m_count = m_reload; m_pcnt = 0; end
            if (!DI[0]) m_pcnt = 0;
            m_en = DI[0]; m_ien = DI[1]; m_os = DI[2];
          end
          3'd1: if (DI[0] && !expiry) m_exp = 0;
          3'd2: m_pre = DI;
          3'd3: m_hi = DI;
          3'd4: begin m_reload = {m_hi, DI}; m_count = m_reload; m_pcnt = 0; end
          default: ;
        endcase
      end
      if (cs && rw && AD == 3'd5) m_shadow = old_count[7:0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_do", 16'(DO), 16'(mdo(AD)));
      check("model_irq", 16'(irq), 16'(m_exp & m_ien));
    end
  end

  task automatic step(input logic c, input logic r, input logic [2:0] a, input logic [7:0] d);
    cs = c; rw = r; AD = a; DI = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [7:0] exp, input string name);
    cs = 1'b1; rw = 1'b1; AD = a; DI = 8'h00;
    #1;
    check(name, 16'(DO), 16'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cs = 1'b0; rw = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Idle with STATUS on DO until expired shows or the bound runs out.
  task automatic wait_exp(output int n);
    n = 0;
    cs = 1'b0; rw = 1'b1; AD = 3'd1;
    #1;
    while (!DO[0] && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    do_reset();
    chk_en = 1'b1;
    // Reset state
    rd_chk(3'd5, 8'hFF, "rst_cnt_hi");
    rd_chk(3'd6, 8'hFF, "rst_cnt_lo");
    rd_chk(3'd1, 8'h00, "rst_status");
    check("rst_irq", 16'(irq), 16'd0);

    // Periodic: expiry 20 clocks after enable, then every 20
    step(1, 0, 3'd2, 8'd3); step(1, 0, 3'd3, 8'h00); step(1, 0, 3'd4, 8'h04);
    step(1, 0, 3'd0, 8'h03);
    wait_exp(n);
    check("per_first", 16'(n), 16'd20);
    check("per_irq_up", 16'(irq), 16'd1);
    step(1, 0, 3'd1, 8'h01);
    check("per_irq_clr", 16'(irq), 16'd0);
    wait_exp(n);
    check("per_second", 16'(n), 16'd19);

    // Oneshot
    do_reset();
    step(1, 0, 3'd2, 8'd0); step(1, 0, 3'd3, 8'h00); step(1, 0, 3'd4, 8'h02);
    step(1, 0, 3'd0, 8'h07);
    wait_exp(n);
    check("os_expire", 16'(n), 16'd3);
    repeat (3) step(0, 1, 3'd7, 8'h00);
    rd_chk(3'd0, 8'h06, "os_ctrl");
    rd_chk(3'd1, 8'h01, "os_status");
    rd_chk(3'd5, 8'h00, "os_cnt_hi");
    rd_chk(3'd6, 8'h02, "os_cnt_lo");

    // Coherent read across 0x0100 -> 0x00FF
    do_reset();
    step(1, 0, 3'd2, 8'd0); step(1, 0, 3'd3, 8'h01); step(1, 0, 3'd4, 8'h02);
    step(1, 0, 3'd0, 8'h01);
    step(0, 1, 3'd7, 8'h00); step(0, 1, 3'd7, 8'h00);
    rd_chk(3'd5, 8'h01, "coh_hi");
    rd_chk(3'd6, 8'h00, "coh_lo");

    // Collisions: clear on expiry edge, RELOAD_LO on tick edge
    do_reset();
    step(1, 0, 3'd2, 8'd3); step(1, 0, 3'd3, 8'h00); step(1, 0, 3'd4, 8'h04);
    step(1, 0, 3'd0, 8'h03);
    repeat (19) step(0, 1, 3'd7, 8'h00);
    step(1, 0, 3'd1, 8'h01);
    check("clr_collide", 16'(DO), 16'h0003);
    step(1, 0, 3'd3, 8'h01);
    step(0, 1, 3'd7, 8'h00); step(0, 1, 3'd7, 8'h00);
    step(1, 0, 3'd4, 8'h00);
    n = 0;
    cs = 1'b0; rw = 1'b1; AD = 3'd5;
    #1;
    check("ld_collide", 16'(DO), 16'h0001);
    while (DO == 8'h01 && n < 20) begin
      step(0, 1, 3'd5, 8'h00);
      n++;
    end
    check("ld_next_tick", 16'(n), 16'd4);
    check("ld_after_tick", 16'(DO), 16'h0000);

    // Reload zero: expiry every tick, irq gated by irq_en
    do_reset();
    step(1, 0, 3'd2, 8'd1); step(1, 0, 3'd3, 8'h00); step(1, 0, 3'd4, 8'h00);
    step(1, 0, 3'd0, 8'h01);
    wait_exp(n);
    check("rz_first", 16'(n), 16'd2);
    step(1, 0, 3'd1, 8'h01);
    check("rz_cleared", 16'(DO), 16'h0002);
    step(0, 1, 3'd1, 8'h00);
    check("rz_again", 16'(DO), 16'h0003);
    check("rz_irq_off", 16'(irq), 16'd0);
    step(1, 0, 3'd0, 8'h03);
    check("rz_irq_on", 16'(irq), 16'd1);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] a;
      logic [7:0] d;
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      case (a)
        3'd2: d = 8'($urandom_range(0, 3));
        3'd3: d = 8'($urandom_range(0, 1));
        3'd4: d = 8'($urandom_range(0, 12));
        default: ;
      endcase
      rst = ($urandom_range(0, 199) == 0);
      step(1'($urandom), 1'($urandom), a, d);
    end
    rst = 1'b0;
    step(0, 1, 3'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
